tdm_demux_4x2: RTL

- Receive end of the 4:1 mux link: the mux sends A, B, C, D over one shared WIDTH-bit line in slots 0..3, and this block rebuilds the four words.
- Slot 0 is marked by SYNC. The block tracks the slot with a counter, stores slots 0..2 in shadow registers, then updates all four outputs together when slot 3 arrives.
- It also flags frame errors and resynchronises. It sits between the shared line and the four consumer registers.

---
 rtl/tdm_demux_4x2.sv | 115 +++++++++++
 1 files changed

// File: rtl/tdm_demux_4x2.sv
// Receive side of the 4:1 TDM link: rebuilds A..D from one shared line, using SYNC
// to lock onto frames and flagging framing errors with immediate resync.
module tdm_demux_4x2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             SYNC,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [1:0]       S,
  output logic             VALID,
  output logic             ERR
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
  logic [WIDTH-1:0] sh0_d, sh1_d, sh2_d;
  logic [WIDTH-1:0] a_d, b_d, c_d, d_d;
  logic [1:0]       s_d;
  logic             valid_d, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      A       <= '0;
      B       <= '0;
      C       <= '0;
      D       <= '0;
      S       <= 2'd0;
      VALID   <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state_q <= state_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      A       <= a_d;
      B       <= b_d;
      C       <= c_d;
      D       <= d_d;
      S       <= s_d;
      VALID   <= valid_d;
      ERR     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    a_d     = A;
    b_d     = B;
    c_d     = C;
    d_d     = D;
    s_d     = S;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (EN) begin
      case (state_q)
        IDLE: begin
          if (SYNC) begin
            sh0_d   = Y;
            s_d     = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (SYNC) begin
            // SYNC anywhere but slot 0 drops the partial frame and restarts on this word
            err_d = (S != 2'd0);
            sh0_d = Y;
            s_d   = 2'd1;
          end else begin
            case (S)
              2'd0: begin
                err_d   = 1'b1;
                s_d     = 2'd0;
                state_d = IDLE;
              end
              2'd1: begin
                sh1_d = Y;
                s_d   = 2'd2;
              end
              2'd2: begin
                sh2_d = Y;
                s_d   = 2'd3;
              end
              default: begin
                a_d     = sh0_q;
                b_d     = sh1_q;
                c_d     = sh2_q;
                d_d     = Y;
                valid_d = 1'b1;
                s_d     = 2'd0;
              end
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
